layer_input_loader: RTL and testbench

//  Feeder for a layer of fully-connected nodes. Accepts a serial byte stream of

---
 rtl/layer_input_loader.sv | 115 +++++++++++
 tb/tb_layer_input_loader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_input_loader.sv
// Serial-to-parallel activation loader for a fully-connected node layer.
// Assembles N_IN bytes into a shadow, commits atomically to Ax, and times the node pipeline.
module layer_input_loader #(
  parameter int N_IN     = 10,
  parameter int DATA_W   = 8,
  parameter int NODE_LAT = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        s_data,
  input  logic                     s_valid,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic [N_IN*DATA_W-1:0]   Ax,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     frame_err
);

  localparam int CNT_W = $clog2(N_IN + 1);
  localparam int LAT_W = $clog2(NODE_LAT + 1);

  typedef enum logic {FILL, WAIT} state_t;

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic [LAT_W-1:0]         lat_cnt;
  logic                     full;
  logic [N_IN*DATA_W-1:0]   shadow;

  logic                     xfer;
  logic                     last_pos;
  logic                     good;
  logic                     bad;
  logic                     expire;
  logic                     commit;
  logic [N_IN*DATA_W-1:0]   merged;
  logic [N_IN*DATA_W-1:0]   commit_vec;

  assign s_ready  = reset & ~full;
  assign xfer     = s_valid & s_ready;
  assign last_pos = (cnt == CNT_W'(N_IN - 1));
  assign good     = xfer & last_pos & s_last;
  assign bad      = xfer & (last_pos ^ s_last);
  assign expire   = (state == WAIT) && (lat_cnt == LAT_W'(1));

  // Shadow with the byte currently on the bus merged in, so a frame can commit on its last transfer.
  always_comb begin
    merged = shadow;
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (cnt == CNT_W'(k)) merged[k*DATA_W +: DATA_W] = s_data;
    end
  end

  always_comb begin
    commit     = 1'b0;
    commit_vec = merged;
    if (state == FILL) begin
      commit = good;
    end else if (expire) begin
      if (full) begin
        commit     = 1'b1;
        commit_vec = shadow;
      end else begin
        commit = good;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= FILL;
      cnt       <= '0;
      lat_cnt   <= '0;
      full      <= 1'b0;
      shadow    <= '0;
      Ax        <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      out_valid <= expire;

      if (xfer) begin
        shadow <= merged;
        if (bad) begin
          frame_err <= 1'b1;
          cnt       <= '0;
        end else if (good) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      if (commit) begin
        Ax      <= commit_vec;
        lat_cnt <= LAT_W'(NODE_LAT);
        state   <= WAIT;
        busy    <= 1'b1;
        full    <= 1'b0;
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt - 1'b1;
        if (expire) begin
          state <= FILL;
          busy  <= 1'b0;
        end else if (good) begin
          // Frame finished early: park it in the shadow and stall the producer until expiry.
          full <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_layer_input_loader.sv
// Bench for layer_input_loader: a short-latency and a long-latency instance checked
// every cycle against a frame-level reference model, plus literal spot checks.
module tb_layer_input_loader;

  localparam int N_IN = 10;
  localparam int DW   = 8;
  localparam int LAT0 = 3;
  localparam int LAT1 = 12;
  localparam int AW   = N_IN * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [DW-1:0] s_data    [2];
  logic          s_valid   [2];
  logic          s_last    [2];
  logic          s_ready   [2];
  logic [AW-1:0] Ax        [2];
  logic          out_valid [2];
  logic          busy      [2];
  logic          frame_err [2];

  layer_input_loader #(.N_IN(N_IN), .DATA_W(DW), .NODE_LAT(LAT0)) dut_a (
    .clk(clk), .reset(reset), .s_data(s_data[0]), .s_valid(s_valid[0]), .s_last(s_last[0]),
    .s_ready(s_ready[0]), .Ax(Ax[0]), .out_valid(out_valid[0]), .busy(busy[0]), .frame_err(frame_err[0]));

  layer_input_loader #(.N_IN(N_IN), .DATA_W(DW), .NODE_LAT(LAT1)) dut_b (
    .clk(clk), .reset(reset), .s_data(s_data[1]), .s_valid(s_valid[1]), .s_last(s_last[1]),
    .s_ready(s_ready[1]), .Ax(Ax[1]), .out_valid(out_valid[1]), .busy(busy[1]), .frame_err(frame_err[1]));

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, int i, logic [AW-1:0] act, logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] t=%0t got=%h expected=%h", name, i, $time, act, exp);
    end
  endtask

  // Reference model: bytes collected per frame, a parked frame, and edges left until the pulse.
  logic [DW-1:0] mbuf  [2][N_IN];
  int            mcnt  [2];
  bit            mfull [2];
  logic [AW-1:0] mpend [2];
  logic [AW-1:0] max   [2];
  int            mrem  [2];
  bit            mov   [2];
  bit            merr  [2];

  task automatic model_step(int i);
    logic [AW-1:0] vec;
    bit done;
    int lat;
    lat  = (i == 0) ? LAT0 : LAT1;
    vec  = '0;
    done = 0;
    if (!reset) begin
      mcnt[i] = 0; mfull[i] = 0; mpend[i] = '0; max[i] = '0;
      mrem[i] = 0; mov[i] = 0; merr[i] = 0;
      return;
    end
    mov[i] = 0;
    if (s_valid[i] && !mfull[i]) begin
      mbuf[i][mcnt[i]] = s_data[i];
      mcnt[i]++;
      if (mcnt[i] == N_IN && s_last[i]) begin
        done = 1;
        for (int k = 0; k < N_IN; k++) vec[k*DW +: DW] = mbuf[i][k];
        mcnt[i] = 0;
      end else if (s_last[i] || mcnt[i] == N_IN) begin
        merr[i] = 1;
        mcnt[i] = 0;
      end
    end
    if (mrem[i] == 0) begin
      if (done) begin max[i] = vec; mrem[i] = lat; end
    end else if (mrem[i] == 1) begin
      mov[i] = 1;
      if (mfull[i]) begin
        max[i] = mpend[i]; mfull[i] = 0; mrem[i] = lat;
      end else if (done) begin
        max[i] = vec; mrem[i] = lat;
      end else begin
        mrem[i] = 0;
      end
    end else begin
      mrem[i]--;
      if (done) begin mfull[i] = 1; mpend[i] = vec; end
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("s_ready",   i, AW'(s_ready[i]),   AW'(reset && !mfull[i]));
      chk("Ax",        i, Ax[i],             max[i]);
      chk("out_valid", i, AW'(out_valid[i]), AW'(mov[i]));
      chk("busy",      i, AW'(busy[i]),      AW'(mrem[i] > 0));
      chk("frame_err", i, AW'(frame_err[i]), AW'(merr[i]));
    end
  end

  // Producer side: called at a negedge; s_ready seen now is what the next posedge samples.
  task automatic send_byte(int i, logic [DW-1:0] d, logic l);
    s_valid[i] = 1'b1;
    s_data[i]  = d;
    s_last[i]  = l;
    for (int t = 0; ; t++) begin
      if (s_ready[i] === 1'b1) break;
      if (t >= 300) begin
        checks++;
        errors++;
        $display("FAIL handshake_timeout[%0d] t=%0t got=s_ready_low expected=s_ready_high", i, $time);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic idle(int i, int n);
    s_valid[i] = 1'b0;
    s_last[i]  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // kind 0: 1..len, kind 1: all 0x7F, kind 2: random, kind 3: 21..
  task automatic send_seq(int i, int kind, int len, bit lastflag);
    logic [DW-1:0] d;
    for (int b = 0; b < len; b++) begin
      case (kind)
        0:       d = DW'(b + 1);
        1:       d = 8'h7F;
        2:       d = DW'($urandom);
        default: d = DW'(21 + b);
      endcase
      send_byte(i, d, lastflag && (b == len - 1));
    end
  endtask

  task automatic rand_producer(int i);
    int len;
    bit lf;
    repeat (40) begin
      len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 10)) : 10;
      lf  = ($urandom_range(0, 5) != 0);
      send_seq(i, 2, len, lf);
      if ($urandom_range(0, 1) == 1) idle(i, int'($urandom_range(1, 3)));
    end
    idle(i, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t got=running expected=finished", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid[i] = 1'b1; s_data[i] = 8'hAA; s_last[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk("rst_s_ready",   0, AW'(s_ready[0]),   '0);
    chk("rst_Ax",        0, Ax[0],             '0);
    chk("rst_out_valid", 0, AW'(out_valid[0]), '0);
    @(posedge clk); #2;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) s_valid[i] = 1'b0;
    @(negedge clk);
    chk("release_s_ready", 0, AW'(s_ready[0]), AW'(1));

    // Single frame 1..10: pulse exactly LAT0 edges after the commit edge.
    fork
      send_seq(0, 0, 10, 1);
      send_seq(1, 0, 10, 1);
    join
    idle(0, 0); idle(1, 0);
    for (int k = 0; k < N_IN; k++) chk("frame_slot", k, AW'(Ax[0][k*DW +: DW]), AW'(k + 1));
    repeat (2) begin
      @(negedge clk);
      chk("early_pulse", 0, AW'(out_valid[0]), '0);
    end
    @(negedge clk);
    chk("pulse", 0, AW'(out_valid[0]), AW'(1));
    @(negedge clk);
    chk("pulse_width", 0, AW'(out_valid[0]), '0);
    repeat (20) @(negedge clk);

    // Back-to-back: the long-latency instance parks frame two and stalls.
    fork
      begin send_seq(0, 0, 10, 1); send_seq(0, 1, 10, 1); end
      begin send_seq(1, 0, 10, 1); send_seq(1, 1, 10, 1); end
    join
    idle(0, 0); idle(1, 0);
    chk("stall_ready", 1, AW'(s_ready[1]), '0);
    chk("fill_ready",  0, AW'(s_ready[0]), AW'(1));
    repeat (2) @(negedge clk);
    chk("parked_pulse",  1, AW'(out_valid[1]), AW'(1));
    chk("parked_commit", 1, AW'(Ax[1][0 +: DW]), AW'(8'h7F));
    repeat (30) @(negedge clk);

    // Framing errors: early s_last, then a missing s_last; good frames still commit.
    fork
      begin send_seq(0, 2, 4, 1); send_seq(0, 0, 10, 1); idle(0, 0); end
      begin send_seq(1, 2, 4, 1); send_seq(1, 0, 10, 1); idle(1, 0); end
    join
    chk("err_sticky", 0, AW'(frame_err[0]), AW'(1));
    chk("err_commit", 0, AW'(Ax[0][0 +: DW]), AW'(1));
    repeat (30) @(negedge clk);
    fork
      begin send_seq(0, 2, 10, 0); send_seq(0, 3, 10, 1); idle(0, 0); end
      begin send_seq(1, 2, 10, 0); send_seq(1, 3, 10, 1); idle(1, 0); end
    join
    repeat (30) @(negedge clk);

    // Last byte of the next frame lands on the expiry edge of the long-latency instance.
    fork
      begin send_seq(0, 0, 10, 1); idle(0, 2); send_seq(0, 3, 10, 1); idle(0, 0); end
      begin send_seq(1, 0, 10, 1); idle(1, 2); send_seq(1, 3, 10, 1); idle(1, 0); end
    join
    chk("coinc_pulse", 1, AW'(out_valid[1]), AW'(1));
    chk("coinc_busy",  1, AW'(busy[1]), AW'(1));
    chk("coinc_Ax",    1, AW'(Ax[1][9*DW +: DW]), AW'(30));
    repeat (30) @(negedge clk);

    // Reset shortly after a commit: nothing pending survives.
    fork
      send_seq(0, 0, 10, 1);
      send_seq(1, 0, 10, 1);
    join
    idle(0, 0); idle(1, 0);
    @(posedge clk); #2 reset = 1'b0;
    @(posedge clk); #2 reset = 1'b1;
    repeat (15) begin
      @(negedge clk);
      chk("post_rst_pulse", 0, AW'(out_valid[0]), '0);
      chk("post_rst_pulse", 1, AW'(out_valid[1]), '0);
    end
    chk("post_rst_Ax", 0, Ax[0], '0);
    fork
      send_seq(0, 3, 10, 1);
      send_seq(1, 3, 10, 1);
    join
    idle(0, 0); idle(1, 0);
    chk("reload_slot0", 0, AW'(Ax[0][0 +: DW]), AW'(21));
    chk("reload_slot9", 0, AW'(Ax[0][9*DW +: DW]), AW'(30));
    repeat (20) @(negedge clk);

    // Randomised traffic with one asynchronous-to-traffic reset pulse.
    fork
      rand_producer(0);
      rand_producer(1);
      begin
        repeat (int'($urandom_range(100, 250))) @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk); #2 reset = 1'b1;
      end
    join
    repeat (30) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
